q_output_layer: RTL and testbench
=================================

# q_output_layer

Final stage of the CartPole SNN datapath. It sits directly downstream of the hidden-layer membrane collector. It consumes one membrane-potential vector per timestep and computes a fixed-point dot product against per-action weights plus bias for each vector. It accumulates these Q contributions over all timesteps, then emits the accumulated Q-values and the greedy (argmax) action.

## Interface
Parameters:
- NUM_INPUTS, 16, hidden neurons per membrane vector
- NUM_ACTIONS, 2, output Q-values (CartPole left/right)
- NUM_TIMESTEPS, 30, vectors per inference
- MEMBRANE_WIDTH, 24, signed membrane width
- WEIGHT_WIDTH, 8, signed weight width
- BIAS_WIDTH, 16, signed bias width, same scale as one product
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output
- Q_WIDTH, 32, signed output Q-value width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- start  input  1  begin new inference; clears accumulators and pipeline
- membranes_in  input  signed MEMBRANE_WIDTH x NUM_INPUTS  membrane vector
- timestep_in  input  5  timestep index of membranes_in
- valid_in  input  1  membranes_in/timestep_in valid this cycle
- weights  input  signed WEIGHT_WIDTH x NUM_ACTIONS x NUM_INPUTS  static weights, indexed [action][input]
- biases  input  signed BIAS_WIDTH x NUM_ACTIONS  static biases
- q_values  output  signed Q_WIDTH x NUM_ACTIONS  accumulated Q-values, held until next start
- action  output  clog2(NUM_ACTIONS)  argmax of q_values
- q_valid  output  1  one-cycle pulse: q_values/action newly updated
- busy  output  1  high from start until q_valid
- seq_error  output  1  sticky: out-of-order timestep seen

## Operation
- States:
  - IDLE: reset state.
  - RUN: accepting vectors.
  - DRAIN: waiting for the pipeline to empty after the final vector.
  - RESULT: one cycle; pulses q_valid, then returns to IDLE.
- start in any state (including mid-RUN or DRAIN):
  - zero the accumulators, expected-timestep counter and pipeline valid bits;
  - clear seq_error;
  - enter RUN.
  - start and valid_in in the same cycle: the vector is ignored.
- Acceptance in RUN:
  - A vector is accepted when valid_in=1 and timestep_in equals the expected counter (starting at 0). The counter then increments.
  - If timestep_in does not match, the vector is dropped, seq_error is set, and the counter is unchanged.
  - valid_in outside RUN is ignored with no error.
  - Accepting timestep NUM_TIMESTEPS-1 moves RUN -> DRAIN.
- Pipeline, per action a:
  - S1 registers NUM_INPUTS products membrane[n]*weights[a][n], each MEMBRANE_WIDTH+WEIGHT_WIDTH bits.
  - S2 registers the sum of the products plus the sign-extended bias[a]. Sum width is product width + clog2(NUM_INPUTS)+1; no overflow is possible.
  - S3 adds the S2 sum into acc[a]. Accumulator width is sum width + clog2(NUM_TIMESTEPS)+1.
- Output computation, when the final vector leaves S3:
  - q_values[a] = acc[a] >>> OUT_SHIFT (arithmetic shift), saturated to the signed Q_WIDTH range.
  - action = index of the maximum q_value; on ties the lowest index wins.
- Between results, q_values and action hold their last values. start does not clear them.
- busy = (state is RUN or DRAIN).

## Timing
- Reset values: q_values=0, action=0, q_valid=0, busy=0, seq_error=0, state IDLE.
- Reset asserted mid-inference: the block returns immediately to reset values; no result is produced.
- Throughput: one vector per cycle, with back-to-back valid_in supported. Gaps of any length between vectors are allowed.
- Latency: if the final vector is accepted in cycle k, q_values/action are registered at the end of cycle k+3, and q_valid=1 during cycle k+4 only.
- The weights and biases inputs must be stable from start until q_valid. They are sampled directly in S1/S2.
- seq_error sets on the cycle after the offending vector and stays high until start or reset.

## Test plan
- Basic accumulation:
  - Stimulus: weights[0][*]=1, weights[1][*]=-1, biases=0, all membranes=1, 30 consecutive vectors with timesteps 0..29.
  - Response: q_values={480,-480}, action=0, q_valid pulses exactly 4 cycles after the last vector, busy falls in the same cycle.
- Bias and shift:
  - Stimulus: membranes=0, biases={5,-3}, OUT_SHIFT=1.
  - Response: q_values={75,-45} after 30 timesteps, action=0.
- Tie and gaps:
  - Stimulus: identical weights for both actions, valid_in with random 0-3 cycle gaps.
  - Response: equal q_values, action=0; the result matches the gap-free run.
- Sequence error:
  - Stimulus: send timestep 0, then timestep 2.
  - Response: seq_error=1 and the vector is dropped. Sending 1..29 afterwards completes normally with seq_error still 1. A new start clears it.
- Saturation:
  - Stimulus: Q_WIDTH=16, membranes=2^23-1, weights=127.
  - Response: q_values saturate to 32767; negated weights give -32768.
- Abort paths:
  - start at timestep 10: the accumulator restarts and the next result reflects only the post-restart vectors.
  - reset at timestep 10: all outputs return to 0, and no q_valid appears until a new start plus 30 vectors.

Source files
------------

// File: rtl/q_output_layer.sv
// Q-value output layer: per-timestep dot product of the membrane vector with per-action
// weights plus bias, accumulated over an inference, then saturated and reduced to a greedy action.
module q_output_layer #(
  parameter int NUM_INPUTS     = 16,
  parameter int NUM_ACTIONS    = 2,
  parameter int NUM_TIMESTEPS  = 30,
  parameter int MEMBRANE_WIDTH = 24,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int BIAS_WIDTH     = 16,
  parameter int OUT_SHIFT      = 0,
  parameter int Q_WIDTH        = 32
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic [NUM_INPUTS-1:0][MEMBRANE_WIDTH-1:0]              membranes_in,
  input  logic [4:0]                                             timestep_in,
  input  logic                                                   valid_in,
  input  logic [NUM_ACTIONS-1:0][NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0] weights,
  input  logic [NUM_ACTIONS-1:0][BIAS_WIDTH-1:0]                 biases,
  output logic [NUM_ACTIONS-1:0][Q_WIDTH-1:0]                    q_values,
  output logic [$clog2(NUM_ACTIONS)-1:0]                         action,
  output logic                                                   q_valid,
  output logic                                                   busy,
  output logic                                                   seq_error
);

  localparam int PROD_W   = MEMBRANE_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W    = PROD_W + $clog2(NUM_INPUTS) + 1;
  localparam int ACC_W    = SUM_W + $clog2(NUM_TIMESTEPS) + 1;
  localparam int EXT_W    = (ACC_W > Q_WIDTH) ? ACC_W : Q_WIDTH;
  localparam int ACTION_W = $clog2(NUM_ACTIONS);

  localparam logic signed [EXT_W-1:0] Q_MAX = {{(EXT_W-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} state_t;

  state_t state, state_next;

  logic [4:0] expected_ts;
  logic       in_run_valid;
  logic       accept;
  logic       seq_bad;
  logic       last_ts;

  logic p1_valid, p1_last;
  logic p2_valid, p2_last;
  logic p3_last;

  logic signed [PROD_W-1:0] prod_d [NUM_ACTIONS][NUM_INPUTS];
  logic signed [PROD_W-1:0] prod_q [NUM_ACTIONS][NUM_INPUTS];
  logic signed [SUM_W-1:0]  sum_d  [NUM_ACTIONS];
  logic signed [SUM_W-1:0]  sum_q  [NUM_ACTIONS];
  logic signed [ACC_W-1:0]  acc    [NUM_ACTIONS];
  logic signed [ACC_W-1:0]  shifted [NUM_ACTIONS];
  logic signed [EXT_W-1:0]  sat    [NUM_ACTIONS];
  logic signed [EXT_W-1:0]  best_val;
  logic [ACTION_W-1:0]      best_idx;

  // start takes priority over a same-cycle vector, so it is excluded from acceptance
  assign in_run_valid = (state == RUN) && valid_in && !start;
  assign accept       = in_run_valid && (timestep_in == expected_ts);
  assign seq_bad      = in_run_valid && (timestep_in != expected_ts);
  assign last_ts      = (expected_ts == 5'(NUM_TIMESTEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (accept && last_ts) state_next = DRAIN;
        DRAIN:   if (p3_last) state_next = RESULT;
        RESULT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state == RUN) || (state == DRAIN);
    q_valid = (state == RESULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_ts <= '0;
      seq_error   <= 1'b0;
    end else if (start) begin
      expected_ts <= '0;
      seq_error   <= 1'b0;
    end else begin
      if (accept)  expected_ts <= expected_ts + 5'd1;
      if (seq_bad) seq_error   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p2_valid <= 1'b0;
      p2_last  <= 1'b0;
      p3_last  <= 1'b0;
    end else if (start) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p2_valid <= 1'b0;
      p2_last  <= 1'b0;
      p3_last  <= 1'b0;
    end else begin
      p1_valid <= accept;
      p1_last  <= accept && last_ts;
      p2_valid <= p1_valid;
      p2_last  <= p1_last;
      p3_last  <= p2_valid && p2_last;
    end
  end

  always_comb begin
    for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
      for (int unsigned n = 0; n < NUM_INPUTS; n++) begin
        prod_d[a][n] = PROD_W'($signed(membranes_in[n])) * PROD_W'($signed(weights[a][n]));
      end
    end
  end

  always_comb begin
    for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
      sum_d[a] = SUM_W'($signed(biases[a]));
      for (int unsigned n = 0; n < NUM_INPUTS; n++) begin
        sum_d[a] = sum_d[a] + SUM_W'(prod_q[a][n]);
      end
    end
  end

  // Datapath registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
      for (int unsigned n = 0; n < NUM_INPUTS; n++) begin
        prod_q[a][n] <= prod_d[a][n];
      end
      sum_q[a] <= sum_d[a];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned a = 0; a < NUM_ACTIONS; a++) acc[a] <= '0;
    end else if (start) begin
      for (int unsigned a = 0; a < NUM_ACTIONS; a++) acc[a] <= '0;
    end else if (p2_valid) begin
      for (int unsigned a = 0; a < NUM_ACTIONS; a++) acc[a] <= acc[a] + ACC_W'(sum_q[a]);
    end
  end

  always_comb begin
    for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
      shifted[a] = acc[a] >>> OUT_SHIFT;
      sat[a]     = EXT_W'(shifted[a]);
      if (sat[a] > Q_MAX)      sat[a] = Q_MAX;
      else if (sat[a] < Q_MIN) sat[a] = Q_MIN;
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_val = sat[0];
    best_idx = '0;
    for (int unsigned a = 1; a < NUM_ACTIONS; a++) begin
      if (sat[a] > best_val) begin
        best_val = sat[a];
        best_idx = ACTION_W'(a);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_values <= '0;
      action   <= '0;
    end else if (p3_last && !start) begin
      for (int unsigned a = 0; a < NUM_ACTIONS; a++) q_values[a] <= sat[a][Q_WIDTH-1:0];
      action <= best_idx;
    end
  end

endmodule

// File: tb/tb_q_output_layer.sv
// Directed bench for q_output_layer: three instances (default, OUT_SHIFT=1, Q_WIDTH=16) share stimulus.
module tb_q_output_layer;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [15:0][23:0]     membranes_in;
  logic [4:0]            timestep_in;
  logic                  valid_in;
  logic [1:0][15:0][7:0] weights;
  logic [1:0][15:0]      biases;

  logic [1:0][31:0] q_d, q_s;
  logic [1:0][15:0] q_t;
  logic [0:0]       act_d, act_s, act_t;
  logic             qv_d, qv_s, qv_t;
  logic             busy_d, busy_s, busy_t;
  logic             se_d, se_s, se_t;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  q_output_layer dut (
    .clk(clk), .reset(reset), .start(start), .membranes_in(membranes_in),
    .timestep_in(timestep_in), .valid_in(valid_in), .weights(weights), .biases(biases),
    .q_values(q_d), .action(act_d), .q_valid(qv_d), .busy(busy_d), .seq_error(se_d));

  q_output_layer #(.OUT_SHIFT(1)) dut_sh (
    .clk(clk), .reset(reset), .start(start), .membranes_in(membranes_in),
    .timestep_in(timestep_in), .valid_in(valid_in), .weights(weights), .biases(biases),
    .q_values(q_s), .action(act_s), .q_valid(qv_s), .busy(busy_s), .seq_error(se_s));

  q_output_layer #(.Q_WIDTH(16)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .membranes_in(membranes_in),
    .timestep_in(timestep_in), .valid_in(valid_in), .weights(weights), .biases(biases),
    .q_values(q_t), .action(act_t), .q_valid(qv_t), .busy(busy_t), .seq_error(se_t));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int ts);
    valid_in    = 1'b1;
    timestep_in = 5'(ts);
    tick();
    valid_in    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_uniform(input int mem, input int w0, input int w1, input int b0, input int b1);
    for (int n = 0; n < 16; n++) begin
      membranes_in[n] = 24'(mem);
      weights[0][n]   = 8'(w0);
      weights[1][n]   = 8'(w1);
    end
    biases[0] = 16'(b0);
    biases[1] = 16'(b1);
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!qv_d && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!qv_d) begin
      failures++;
      $display("FAIL %s_timeout q_valid=%0b required=1 within 20 cycles", name, qv_d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (q_d !== '0 || act_d !== 1'b0 || qv_d !== 1'b0 || busy_d !== 1'b0 || se_d !== 1'b0) begin
      failures++;
      $display("FAIL reset_state q=%h act=%0b qv=%0b busy=%0b se=%0b required all 0", q_d, act_d, qv_d, busy_d, se_d);
    end
    checks++;
    if (q_t !== '0 || qv_t !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_q16 q=%h qv=%0b required 0", q_t, qv_t);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_uniform(1, 1, -1, 0, 0);
    send_vec(7);
    checks++;
    if (se_d !== 1'b0 || busy_d !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid_ignored se=%0b busy=%0b required 0 0", se_d, busy_d);
    end
    do_start();
    checks++;
    if (busy_d !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got=%0b required=1", busy_d);
    end
    for (int t = 0; t < 30; t++) send_vec(t);
    checks++;
    if (qv_d !== 1'b0) begin
      failures++;
      $display("FAIL latency_k1 q_valid=%0b required=0", qv_d);
    end
    tick();
    checks++;
    if (qv_d !== 1'b0) begin
      failures++;
      $display("FAIL latency_k2 q_valid=%0b required=0", qv_d);
    end
    tick();
    checks++;
    if (qv_d !== 1'b0 || busy_d !== 1'b1) begin
      failures++;
      $display("FAIL latency_k3 q_valid=%0b busy=%0b required 0 1", qv_d, busy_d);
    end
    tick();
    checks++;
    if (qv_d !== 1'b1 || busy_d !== 1'b0) begin
      failures++;
      $display("FAIL latency_k4 q_valid=%0b busy=%0b required 1 0", qv_d, busy_d);
    end
    checks++;
    if ($signed(q_d[0]) !== 480 || $signed(q_d[1]) !== -480 || act_d !== 1'b0) begin
      failures++;
      $display("FAIL basic_q got=%0d,%0d act=%0d required 480,-480 act=0", $signed(q_d[0]), $signed(q_d[1]), act_d);
    end
    checks++;
    if ($signed(q_s[0]) !== 240 || $signed(q_s[1]) !== -240 || qv_s !== 1'b1) begin
      failures++;
      $display("FAIL basic_q_shift got=%0d,%0d qv=%0b required 240,-240 qv=1", $signed(q_s[0]), $signed(q_s[1]), qv_s);
    end
    tick();
    checks++;
    if (qv_d !== 1'b0 || $signed(q_d[0]) !== 480 || $signed(q_d[1]) !== -480) begin
      failures++;
      $display("FAIL basic_hold qv=%0b q=%0d,%0d required 0 480,-480", qv_d, $signed(q_d[0]), $signed(q_d[1]));
    end
  endtask

  task automatic test_bias_shift();
    set_uniform(0, 1, -1, 5, -3);
    do_start();
    for (int t = 0; t < 30; t++) send_vec(t);
    wait_result("bias");
    checks++;
    if ($signed(q_s[0]) !== 75 || $signed(q_s[1]) !== -45 || act_s !== 1'b0) begin
      failures++;
      $display("FAIL bias_shift_q got=%0d,%0d act=%0d required 75,-45 act=0", $signed(q_s[0]), $signed(q_s[1]), act_s);
    end
    checks++;
    if ($signed(q_d[0]) !== 150 || $signed(q_d[1]) !== -90) begin
      failures++;
      $display("FAIL bias_noshift_q got=%0d,%0d required 150,-90", $signed(q_d[0]), $signed(q_d[1]));
    end
  endtask

  task automatic test_tie_gaps();
    set_uniform(0, 3, 3, -2, -2);
    for (int n = 0; n < 16; n++) membranes_in[n] = 24'(n - 5);
    do_start();
    for (int t = 0; t < 30; t++) begin
      send_vec(t);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_result("tie_gaps");
    checks++;
    if ($signed(q_d[0]) !== 3540 || $signed(q_d[1]) !== 3540 || act_d !== 1'b0) begin
      failures++;
      $display("FAIL tie_gaps_q got=%0d,%0d act=%0d required 3540,3540 act=0", $signed(q_d[0]), $signed(q_d[1]), act_d);
    end
    tick();
    do_start();
    for (int t = 0; t < 30; t++) send_vec(t);
    wait_result("tie_nogap");
    checks++;
    if ($signed(q_d[0]) !== 3540 || $signed(q_d[1]) !== 3540 || act_d !== 1'b0 || $signed(q_s[0]) !== 1770) begin
      failures++;
      $display("FAIL tie_nogap_q got=%0d,%0d act=%0d sh=%0d required 3540,3540 act=0 sh=1770", $signed(q_d[0]), $signed(q_d[1]), act_d, $signed(q_s[0]));
    end
  endtask

  task automatic test_seq_error();
    set_uniform(1, 1, -1, 0, 0);
    tick();
    do_start();
    send_vec(0);
    checks++;
    if (se_d !== 1'b0) begin
      failures++;
      $display("FAIL seq_before got=%0b required=0", se_d);
    end
    set_uniform(100, 1, -1, 0, 0);
    send_vec(2);
    set_uniform(1, 1, -1, 0, 0);
    checks++;
    if (se_d !== 1'b1) begin
      failures++;
      $display("FAIL seq_set got=%0b required=1", se_d);
    end
    for (int t = 1; t < 30; t++) send_vec(t);
    wait_result("seq");
    checks++;
    if ($signed(q_d[0]) !== 480 || $signed(q_d[1]) !== -480 || se_d !== 1'b1) begin
      failures++;
      $display("FAIL seq_result q=%0d,%0d se=%0b required 480,-480 se=1", $signed(q_d[0]), $signed(q_d[1]), se_d);
    end
    tick();
    do_start();
    checks++;
    if (se_d !== 1'b0) begin
      failures++;
      $display("FAIL seq_clear got=%0b required=0", se_d);
    end
  endtask

  task automatic test_saturation();
    set_uniform(8388607, 127, -127, 0, 0);
    do_start();
    for (int t = 0; t < 30; t++) send_vec(t);
    wait_result("sat");
    checks++;
    if ($signed(q_t[0]) !== 32767 || $signed(q_t[1]) !== -32768 || act_t !== 1'b0) begin
      failures++;
      $display("FAIL sat_q16 got=%0d,%0d act=%0d required 32767,-32768 act=0", $signed(q_t[0]), $signed(q_t[1]), act_t);
    end
    checks++;
    if ($signed(q_d[0]) !== 2147483647 || q_d[1] !== 32'h80000000) begin
      failures++;
      $display("FAIL sat_q32 got=%0d,%0d required 2147483647,-2147483648", $signed(q_d[0]), $signed(q_d[1]));
    end
    checks++;
    if ($signed(q_s[0]) !== 2147483647 || q_s[1] !== 32'h80000000) begin
      failures++;
      $display("FAIL sat_q32_shift got=%0d,%0d required 2147483647,-2147483648", $signed(q_s[0]), $signed(q_s[1]));
    end
  endtask

  task automatic test_abort_start();
    set_uniform(1, -1, 1, 0, 0);
    tick();
    do_start();
    for (int t = 0; t < 10; t++) send_vec(t);
    start       = 1'b1;
    valid_in    = 1'b1;
    timestep_in = 5'd0;
    tick();
    start    = 1'b0;
    valid_in = 1'b0;
    for (int t = 0; t < 30; t++) send_vec(t);
    wait_result("abort_start");
    checks++;
    if ($signed(q_d[0]) !== -480 || $signed(q_d[1]) !== 480 || act_d !== 1'b1 || se_d !== 1'b0) begin
      failures++;
      $display("FAIL abort_start_q got=%0d,%0d act=%0d se=%0b required -480,480 act=1 se=0", $signed(q_d[0]), $signed(q_d[1]), act_d, se_d);
    end
  endtask

  task automatic test_abort_reset();
    int seen;
    seen = 0;
    set_uniform(1, -1, 1, 0, 0);
    tick();
    do_start();
    for (int t = 0; t < 10; t++) send_vec(t);
    reset = 1'b1;
    #1;
    checks++;
    if (q_d !== '0 || act_d !== 1'b0 || busy_d !== 1'b0 || qv_d !== 1'b0 || se_d !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset_outputs q=%h act=%0b busy=%0b qv=%0b se=%0b required all 0", q_d, act_d, busy_d, qv_d, se_d);
    end
    tick();
    reset = 1'b0;
    tick();
    for (int t = 10; t < 30; t++) begin
      send_vec(t);
      if (qv_d) seen++;
    end
    for (int t = 0; t < 30; t++) begin
      send_vec(t);
      if (qv_d) seen++;
    end
    repeat (6) begin
      tick();
      if (qv_d) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_reset_no_result q_valid_cycles=%0d required=0", seen);
    end
    do_start();
    for (int t = 0; t < 30; t++) send_vec(t);
    wait_result("abort_reset");
    checks++;
    if ($signed(q_d[0]) !== -480 || $signed(q_d[1]) !== 480 || act_d !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset_q got=%0d,%0d act=%0d required -480,480 act=1", $signed(q_d[0]), $signed(q_d[1]), act_d);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    valid_in     = 1'b0;
    timestep_in  = '0;
    membranes_in = '0;
    weights      = '0;
    biases       = '0;
    test_reset();
    test_basic();
    test_bias_shift();
    test_tie_gaps();
    test_seq_error();
    test_saturation();
    test_abort_start();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
